gshare_ongorucu_p: RTL
======================

// Module: gshare_ongorucu_p
// PURPOSE
//  Parametrised gshare direction predictor for the fetch (getir) stage, trained from execute (yurut).
//  Fetch-side prediction and target are combinational, for RV32 B-type and JAL.
//  Table and global history update on the clock edge.
//  A reset-clear FSM sweeps the counter table; hazir stays low until the table is clean.
// PARAMETERS
//  INDEKS_BIT      10  table index width; table holds 2**INDEKS_BIT counters
//  GECMIS_BIT      10  global history length; legal range 1..INDEKS_BIT
//  SAYAC_BIT       2   saturating counter width; legal range 1..4
//  SAYAC_BASLANGIC 2   counter clear value; default is weakly taken, 2**(SAYAC_BIT-1)
// PORTS
//  clk             in  1   clock; all state changes on its rising edge
//  rst             in  1   synchronous, active-high reset
//  getir_ps        in  32  fetch PC
//  getir_buyruk    in  32  fetch instruction
//  getir_gecerli   in  1   fetch instruction valid
//  yurut_ps        in  32  PC of the instruction resolved in execute
//  yurut_buyruk    in  32  instruction resolved in execute
//  yurut_dallan    in  1   resolved direction; 1 = taken
//  yurut_gecerli   in  1   execute result valid
//  sonuc_dallan    out 1   predicted taken (combinational)
//  sonuc_dallan_ps out 32  predicted next PC (combinational)
//  hazir           out 1   table clear finished; prediction and training active
// BEHAVIOUR
//  Index: idx = PC[INDEKS_BIT+1:2] ^ {zero-pad, gecmis[GECMIS_BIT-1:0]}.
//   Fetch uses getir_ps; update uses yurut_ps. Both use the current registered history.
//  Decode: opcode 7'b1100011 = B-type; 7'b1101111 = JAL.
//  FSM: TEMIZLE -> HAZIR.
//   rst=1: enter TEMIZLE, clear counter sayac=0, clear gecmis=0.
//   TEMIZLE: one table entry set to SAYAC_BASLANGIC per cycle, index = sayac. hazir=0.
//   TEMIZLE exit: after entry 2**INDEKS_BIT-1 is written, go to HAZIR. hazir=1 from the next cycle.
//   rst asserted mid-clear: restart the sweep at entry 0.
//   rst=1 always has priority over any update in the same cycle.
//  Prediction (combinational), evaluated in priority order:
//   hazir=0 or getir_gecerli=0: sonuc_dallan=0, sonuc_dallan_ps=getir_ps+4. Same values apply during and after reset.
//   JAL: sonuc_dallan=1, sonuc_dallan_ps = getir_ps + sext J-imm {b31,b19:12,b20,b30:21,0}.
//   B-type: sonuc_dallan = tablo[idx][SAYAC_BIT-1].
//    Taken target = getir_ps + sext B-imm {b31,b7,b30:25,b11:8,0}.
//    Not taken target = getir_ps+4.
//   Any other opcode: sonuc_dallan=0, sonuc_dallan_ps=getir_ps+4.
//   All adds are 32-bit and wrap modulo 2**32.
//  Training (registered; only when hazir=1, yurut_gecerli=1, and yurut_buyruk is B-type):
//   Counter: taken -> +1, saturating at 2**SAYAC_BIT-1; not taken -> -1, saturating at 0.
//   History: gecmis <= {gecmis[GECMIS_BIT-2:0], yurut_dallan}. GECMIS_BIT=1 just loads yurut_dallan.
//   JAL and non-branch instructions in execute change neither table nor history.
//  Same cycle fetch/update on the same idx: fetch sees the pre-update counter and history.
//   The new value becomes visible the following cycle.
//  Counters are only written by the TEMIZLE sweep and by training. No other write path.
// CONFIGURATION
//  ONGORUCU_ISTAT_EN defined: two extra output ports, both cleared by rst.
//   istat_dallan [31:0]: count of trained B-type updates.
//   istat_yanlis [31:0]: count of updates where the pre-update counter MSB != yurut_dallan.
//   Both counters saturate at 32'hFFFFFFFF. Neither counts during TEMIZLE.
//  ONGORUCU_ISTAT_EN undefined: ports and counters are absent.
//   Prediction and training behaviour is identical either way.
// TESTING
//  1. Reset: rst=1 for one cycle with defaults.
//     -> hazir=0 for 1024 cycles, then 1. Every entry reads 2'b10.
//     -> During the clear, a B-type fetch gives sonuc_dallan=0, sonuc_dallan_ps=getir_ps+4.
//  2. B-type predict: getir_ps=0x100, beq with B-imm=-8, fresh table, history 0.
//     -> sonuc_dallan=1, sonuc_dallan_ps=0x0F8.
//     -> Then train 2x not taken at yurut_ps=0x100 with history 0: counter goes 10->01->00, history 00.
//     -> A re-fetch at the same index gives sonuc_dallan=0, sonuc_dallan_ps=0x104.
//  3. Saturation: train one index 5x taken (stays 2'b11), then 1x not taken (2'b10).
//     -> Prediction stays taken.
//     -> Repeat with 5x not taken: counter holds 2'b00 and does not wrap.
//  4. History/aliasing: train a taken B-type at 0x200; history becomes 1.
//     -> A fetch at 0x204 then uses idx 0x081^0x001=0x080, the same entry as 0x200 with history 0.
//  5. Collision and reset mid-clear:
//     -> Same-cycle fetch/update on one idx: fetch output reflects the old counter.
//     -> rst at clear cycle 500: hazir stays low 1024 more cycles.
//     -> A simultaneous update with rst is dropped.
//  6. JAL and the ISTAT build:
//     -> JAL with J-imm=+0x800 at 0x1000 gives 1, 0x1800. A JAL in execute leaves istat_dallan unchanged.
//     -> With ONGORUCU_ISTAT_EN: 3 B-type updates with 1 mispredict give istat_dallan=3, istat_yanlis=1.

Source files
------------

// File: rtl/gshare_ongorucu_p.sv
// Parametrised gshare direction predictor: combinational fetch-side prediction, execute-side training.
// Optional statistics counters are enabled by defining ONGORUCU_ISTAT_EN.
module gshare_ongorucu_p #(
  parameter int INDEKS_BIT      = 10,
  parameter int GECMIS_BIT      = 10,
  parameter int SAYAC_BIT       = 2,
  parameter int SAYAC_BASLANGIC = 2 ** (SAYAC_BIT - 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_getir_ps,
  input  logic [31:0] i_getir_buyruk,
  input  logic        i_getir_gecerli,
  input  logic [31:0] i_yurut_ps,
  input  logic [31:0] i_yurut_buyruk,
  input  logic        i_yurut_dallan,
  input  logic        i_yurut_gecerli,
  output logic        o_sonuc_dallan,
  output logic [31:0] o_sonuc_dallan_ps,
  output logic        o_hazir
`ifdef ONGORUCU_ISTAT_EN
  ,
  output logic [31:0] o_istat_dallan,
  output logic [31:0] o_istat_yanlis
`endif
);

  localparam int TABLO_BOY = 2 ** INDEKS_BIT;
  localparam logic [6:0] OPC_B   = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [SAYAC_BIT-1:0]  SAYAC_MAKS = {SAYAC_BIT{1'b1}};
  localparam logic [SAYAC_BIT-1:0]  SAYAC_ILK  = SAYAC_BIT'(SAYAC_BASLANGIC);
  localparam logic [INDEKS_BIT-1:0] SON_INDEKS = INDEKS_BIT'(TABLO_BOY - 1);

  typedef enum logic {TEMIZLE, HAZIR} durum_t;

  durum_t                 r_durum;
  durum_t                 w_durumSonraki;
  logic [INDEKS_BIT-1:0]  r_sayac;
  logic [GECMIS_BIT-1:0]  r_gecmis;
  logic [SAYAC_BIT-1:0]   r_tablo [TABLO_BOY];

  logic                   w_hazir;
  logic [INDEKS_BIT-1:0]  w_gecmisGenis;
  logic [INDEKS_BIT-1:0]  w_getirIdx;
  logic [INDEKS_BIT-1:0]  w_yurutIdx;
  logic [SAYAC_BIT-1:0]   w_getirSayac;
  logic [SAYAC_BIT-1:0]   w_yurutSayac;
  logic [SAYAC_BIT-1:0]   w_sayacYeni;
  logic [GECMIS_BIT:0]    w_gecmisKaydir;
  logic                   w_egit;
  logic [31:0]            w_arti4;
  logic [31:0]            w_bImm;
  logic [31:0]            w_jImm;
  logic                   w_unused;

  assign w_gecmisGenis  = INDEKS_BIT'(r_gecmis);
  assign w_getirIdx     = i_getir_ps[INDEKS_BIT+1:2] ^ w_gecmisGenis;
  assign w_yurutIdx     = i_yurut_ps[INDEKS_BIT+1:2] ^ w_gecmisGenis;
  assign w_getirSayac   = r_tablo[w_getirIdx];
  assign w_yurutSayac   = r_tablo[w_yurutIdx];
  assign w_gecmisKaydir = {r_gecmis, i_yurut_dallan};
  assign w_egit         = w_hazir && i_yurut_gecerli && (i_yurut_buyruk[6:0] == OPC_B);
  assign w_arti4        = i_getir_ps + 32'd4;
  assign w_bImm = {{19{i_getir_buyruk[31]}}, i_getir_buyruk[31], i_getir_buyruk[7],
                   i_getir_buyruk[30:25], i_getir_buyruk[11:8], 1'b0};
  assign w_jImm = {{11{i_getir_buyruk[31]}}, i_getir_buyruk[31], i_getir_buyruk[19:12],
                   i_getir_buyruk[20], i_getir_buyruk[30:21], 1'b0};
  assign w_unused = ^{i_yurut_ps[31:INDEKS_BIT+2], i_yurut_ps[1:0], i_yurut_buyruk[31:7],
                      w_gecmisKaydir[GECMIS_BIT]};
  assign o_hazir = w_hazir;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_durum <= TEMIZLE;
      r_sayac <= '0;
    end else begin
      r_durum <= w_durumSonraki;
      if (r_durum == TEMIZLE) r_sayac <= r_sayac + INDEKS_BIT'(1);
    end
  end

  always_comb begin
    w_durumSonraki = r_durum;
    w_hazir        = 1'b0;
    case (r_durum)
      TEMIZLE: if (r_sayac == SON_INDEKS) w_durumSonraki = HAZIR;
      HAZIR:   w_hazir = 1'b1;
      default: w_durumSonraki = TEMIZLE;
    endcase
  end

  always_comb begin
    w_sayacYeni = w_yurutSayac;
    if (i_yurut_dallan) begin
      if (w_yurutSayac != SAYAC_MAKS) w_sayacYeni = w_yurutSayac + SAYAC_BIT'(1);
    end else begin
      if (w_yurutSayac != '0) w_sayacYeni = w_yurutSayac - SAYAC_BIT'(1);
    end
  end

  // Reset blocks every table write; the sweep itself fills the table afterwards.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_durum == TEMIZLE) r_tablo[r_sayac] <= SAYAC_ILK;
      else if (w_egit) r_tablo[w_yurutIdx] <= w_sayacYeni;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_gecmis <= '0;
    else if (w_egit) r_gecmis <= w_gecmisKaydir[GECMIS_BIT-1:0];
  end

  always_comb begin
    o_sonuc_dallan    = 1'b0;
    o_sonuc_dallan_ps = w_arti4;
    if (w_hazir && i_getir_gecerli) begin
      if (i_getir_buyruk[6:0] == OPC_JAL) begin
        o_sonuc_dallan    = 1'b1;
        o_sonuc_dallan_ps = i_getir_ps + w_jImm;
      end else if (i_getir_buyruk[6:0] == OPC_B) begin
        o_sonuc_dallan = w_getirSayac[SAYAC_BIT-1];
        if (w_getirSayac[SAYAC_BIT-1]) o_sonuc_dallan_ps = i_getir_ps + w_bImm;
      end
    end
  end

`ifdef ONGORUCU_ISTAT_EN
  logic [31:0] r_istatDallan;
  logic [31:0] r_istatYanlis;

  // Misprediction compares the pre-update counter MSB against the resolved direction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_istatDallan <= '0;
      r_istatYanlis <= '0;
    end else if (w_egit) begin
      if (r_istatDallan != 32'hFFFFFFFF) r_istatDallan <= r_istatDallan + 32'd1;
      if ((w_yurutSayac[SAYAC_BIT-1] != i_yurut_dallan) && (r_istatYanlis != 32'hFFFFFFFF))
        r_istatYanlis <= r_istatYanlis + 32'd1;
    end
  end

  assign o_istat_dallan = r_istatDallan;
  assign o_istat_yanlis = r_istatYanlis;
`endif

endmodule
